subleq_sequencer: RTL and testbench

Control FSM that sequences the SUBLEQ datapath (ir <- M[pc]; M[b] <- M[b] - M[a]; if result <= 0 then pc <- c else pc <- pc+1) over a shared dual-port synchronous memory. It replaces free-running phase counters with explicit states, start/stop control, halt detection and a signed branch test. It sits between the top level and the dual-port memory and owns both memory ports.

---
 rtl/subleq_sequencer_if.sv | 28 ++
 rtl/subleq_sequencer.sv | 144 ++++++++++++++
 tb/tb_subleq_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/subleq_sequencer_if.sv
// subleq_mem_if: dual-port synchronous memory bus between the SUBLEQ sequencer and its memory.
// Revision: 1.0
`default_nettype none

interface subleq_mem_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr1;
  logic              mem_we1;
  logic [WORD_W-1:0] mem_wdata1;
  logic [WORD_W-1:0] mem_rdata1;
  logic [ADDR_W-1:0] mem_addr2;
  logic              mem_we2;
  logic [WORD_W-1:0] mem_rdata2;

  modport master (
    output mem_addr1, mem_we1, mem_wdata1, mem_addr2, mem_we2,
    input  mem_rdata1, mem_rdata2
  );

  modport slave (
    input  mem_addr1, mem_we1, mem_wdata1, mem_addr2, mem_we2,
    output mem_rdata1, mem_rdata2
  );
endinterface

`default_nettype wire

// File: rtl/subleq_sequencer.sv
// subleq_sequencer: FETCH/OPERAND/EXEC control FSM for a SUBLEQ core with halt, start/stop and a signed branch.
// Optional macro SUBLEQ_SEQ_PERF_EN adds the o_instret retired-instruction counter. Revision: 1.0
`default_nettype none

module subleq_sequencer #(
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop_req,
  subleq_mem_if.master      mem,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_retire
`ifdef SUBLEQ_SEQ_PERF_EN
  ,
  output logic [31:0]       o_instret
`endif
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_FETCH   = 3'd1;
  localparam logic [2:0] c_ST_OPERAND = 3'd2;
  localparam logic [2:0] c_ST_EXEC    = 3'd3;
  localparam logic [2:0] c_ST_HALTED  = 3'd4;

  localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] c_HALT_PC  = {ADDR_W{1'b1}};

  generate
    if (3 * ADDR_W > WORD_W) begin : g_cfg_check
      $error("subleq_sequencer: 3*ADDR_W must not exceed WORD_W");
    end
  endgenerate

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  // Only b and c are needed after OPERAND; a is consumed straight off the read port.
  logic [2*ADDR_W-1:0] r_ir_bc;

  logic [ADDR_W-1:0]   w_rd_a;
  logic [ADDR_W-1:0]   w_rd_b;
  logic [ADDR_W-1:0]   w_b;
  logic [ADDR_W-1:0]   w_c;
  logic [WORD_W-1:0]   w_res;
  logic                w_taken;
  logic                w_halt;
  logic [ADDR_W-1:0]   w_pc_inc;

  assign w_rd_a   = mem.mem_rdata1[3*ADDR_W-1:2*ADDR_W];
  assign w_rd_b   = mem.mem_rdata1[2*ADDR_W-1:ADDR_W];
  assign w_b      = r_ir_bc[2*ADDR_W-1:ADDR_W];
  assign w_c      = r_ir_bc[ADDR_W-1:0];
  assign w_res    = mem.mem_rdata1 - mem.mem_rdata2;
  assign w_taken  = w_res[WORD_W-1] | (w_res == '0);
  assign w_halt   = w_taken && (w_c == c_HALT_PC);
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (i_start) w_state_nxt = c_ST_FETCH;
      c_ST_FETCH:   w_state_nxt = c_ST_OPERAND;
      c_ST_OPERAND: w_state_nxt = c_ST_EXEC;
      c_ST_EXEC: begin
        if (w_halt)          w_state_nxt = c_ST_HALTED;
        else if (i_stop_req) w_state_nxt = c_ST_IDLE;
        else                 w_state_nxt = c_ST_FETCH;
      end
      c_ST_HALTED:  if (i_start) w_state_nxt = c_ST_FETCH;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Memory controls decode from state alone, so reset silences a pending write immediately.
  always_comb begin
    mem.mem_addr1  = '0;
    mem.mem_we1    = 1'b0;
    mem.mem_wdata1 = '0;
    mem.mem_addr2  = '0;
    case (r_state)
      c_ST_FETCH: mem.mem_addr1 = r_pc;
      c_ST_OPERAND: begin
        mem.mem_addr1 = w_rd_b;
        mem.mem_addr2 = w_rd_a;
      end
      c_ST_EXEC: begin
        mem.mem_addr1  = w_b;
        mem.mem_we1    = 1'b1;
        mem.mem_wdata1 = w_res;
      end
      default: ;
    endcase
  end

  assign mem.mem_we2 = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_pc    <= c_RESET_PC;
      r_ir_bc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == c_ST_OPERAND) begin
        r_ir_bc <= mem.mem_rdata1[2*ADDR_W-1:0];
      end
      if (r_state == c_ST_EXEC) begin
        r_pc <= w_taken ? w_c : w_pc_inc;
      end else if (r_state == c_ST_HALTED && i_start) begin
        r_pc <= c_RESET_PC;
      end
    end
  end

`ifdef SUBLEQ_SEQ_PERF_EN
  logic [31:0] r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
    end else if (r_state == c_ST_EXEC) begin
      r_instret <= r_instret + 32'd1;
    end else if (r_state == c_ST_HALTED && i_start) begin
      r_instret <= '0;
    end
  end

  assign o_instret = r_instret;
`endif

  assign o_pc     = r_pc;
  assign o_busy   = (r_state == c_ST_FETCH) || (r_state == c_ST_OPERAND) || (r_state == c_ST_EXEC);
  assign o_halted = (r_state == c_ST_HALTED);
  assign o_retire = (r_state == c_ST_EXEC);

endmodule

`default_nettype wire

// File: tb/tb_subleq_sequencer.sv
// tb_subleq_sequencer: directed tests against an instruction-level SUBLEQ model plus literal expectations.
// Revision: 1.0
`default_nettype none

module tb_subleq_sequencer;
  localparam int WORD_W   = 32;
  localparam int ADDR_W   = 10;
  localparam int RESET_PC = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop_req;
  logic [9:0]  pc;
  logic        busy;
  logic        halted;
  logic        retire;
`ifdef SUBLEQ_SEQ_PERF_EN
  logic [31:0] instret;
`endif

  subleq_mem_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) mif ();

  subleq_sequencer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_stop_req (stop_req),
    .mem        (mif),
    .o_pc       (pc),
    .o_busy     (busy),
    .o_halted   (halted),
    .o_retire   (retire)
`ifdef SUBLEQ_SEQ_PERF_EN
    ,
    .o_instret  (instret)
`endif
  );

  always #5 clk = ~clk;

  // Dual-port synchronous memory the sequencer drives; reads return the pre-write value.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (mif.mem_we1) ram[mif.mem_addr1] <= mif.mem_wdata1;
    mif.mem_rdata1 <= ram[mif.mem_addr1];
    mif.mem_rdata2 <= ram[mif.mem_addr2];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Instruction-level reference: memory image, pc, halt flag and retire count.
  logic [31:0] gm [1024];
  logic [9:0]  m_pc;
  logic        m_halted;
  logic [31:0] m_instret;
  bit          chk_en = 1'b0;
  logic [31:0] m_ir, m_res;
  logic [9:0]  m_a, m_b, m_c;

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("m_we2", {31'd0, mif.mem_we2}, 32'd0);
      chk("m_pc", {22'd0, pc}, {22'd0, m_pc});
      chk("m_halted", {31'd0, halted}, {31'd0, m_halted});
`ifdef SUBLEQ_SEQ_PERF_EN
      chk("m_instret", instret, m_instret);
`endif
      if (retire) begin
        m_ir  = gm[m_pc];
        m_a   = m_ir[29:20];
        m_b   = m_ir[19:10];
        m_c   = m_ir[9:0];
        m_res = gm[m_b] - gm[m_a];
        chk("m_we1", {31'd0, mif.mem_we1}, 32'd1);
        chk("m_wb_addr", {22'd0, mif.mem_addr1}, {22'd0, m_b});
        chk("m_wb_data", mif.mem_wdata1, m_res);
        gm[m_b]   = m_res;
        m_instret = m_instret + 32'd1;
        if ($signed(m_res) <= 0) begin
          m_pc = m_c;
          if (m_c == 10'h3FF) m_halted = 1'b1;
        end else begin
          m_pc = m_pc + 10'd1;
        end
      end else begin
        chk("m_quiet_we1", {31'd0, mif.mem_we1}, 32'd0);
      end
    end
  end

  function automatic logic [31:0] instr(input int a, input int b, input int c);
    return (32'(a) << 20) | (32'(b) << 10) | 32'(c);
  endfunction

  task automatic put(input int addr, input logic [31:0] data);
    ram[addr] <= data;
    gm[addr] = data;
  endtask

  task automatic load_clear();
    for (int i = 0; i < 1024; i++) put(i, 32'd0);
  endtask

  task automatic model_reset();
    m_pc      = 10'd11;
    m_halted  = 1'b0;
    m_instret = 32'd0;
  endtask

  task automatic do_reset();
    chk_en   = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    stop_req = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst    = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wait_retire(output int n);
    n = 0;
    while (!retire && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!retire) chk("retire_timeout", 32'd0, 32'd1);
  endtask

  // One instruction from IDLE with stop_req held, so the core parks afterwards.
  task automatic step(input string name, input logic [9:0] eb, input logic [31:0] ew, input logic [9:0] epc);
    int n;
    stop_req = 1'b1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_fetch_addr"}, {22'd0, mif.mem_addr1}, {22'd0, m_pc});
    wait_retire(n);
    chk({name, "_latency"}, 32'(n), 32'd2);
    chk({name, "_wb_addr"}, {22'd0, mif.mem_addr1}, {22'd0, eb});
    chk({name, "_wb_data"}, mif.mem_wdata1, ew);
    @(posedge clk); #1;
    chk({name, "_next_pc"}, {22'd0, pc}, {22'd0, epc});
    chk({name, "_mem"}, ram[eb], ew);
    stop_req = 1'b0;
  endtask

  initial begin
    int n;
    int wr;
    // Reset state and first fetch, then a non-taken step (3-5=... no: 5-3=2).
    rst = 1'b1; start = 1'b0; stop_req = 1'b0;
    load_clear();
    put(11, instr(20, 21, 30)); put(20, 3); put(21, 5);
    #2;
    chk("rst_pc", {22'd0, pc}, 32'd11);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_we1", {31'd0, mif.mem_we1}, 32'd0);
    chk("rst_we2", {31'd0, mif.mem_we2}, 32'd0);
    chk("rst_addr1", {22'd0, mif.mem_addr1}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    @(posedge clk); #1;
    model_reset(); rst = 1'b0; chk_en = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    step("t2", 10'd21, 32'd2, 10'd12);
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // Taken on zero and on negative.
    do_reset(); put(20, 5); put(21, 5);
    step("t3a", 10'd21, 32'd0, 10'd30);
    do_reset(); put(20, 7); put(21, 5);
    step("t3b", 10'd21, 32'hFFFF_FFFE, 10'd30);

    // Signed overflow stays positive; pc wraps past 1023.
    do_reset(); put(20, 1); put(21, 32'h8000_0000);
    step("t4a", 10'd21, 32'h7FFF_FFFF, 10'd12);
    do_reset();
    put(11, instr(500, 500, 1022)); put(500, 77);
    put(1022, instr(20, 21, 5)); put(20, 1); put(21, 10);
    put(1023, instr(20, 22, 5)); put(22, 10);
    step("t4b_aeqb", 10'd500, 32'd0, 10'd1022);
    step("t4b_to1023", 10'd21, 32'd9, 10'd1023);
    step("t4b_wrap", 10'd22, 32'd9, 10'd0);

    // Halt beats stop_req, stays quiet, restart from RESET_PC.
    do_reset(); put(11, instr(20, 21, 1023)); put(20, 5); put(21, 5);
    step("t5", 10'd21, 32'd0, 10'd1023);
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    wr = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mif.mem_we1) wr++;
    end
    chk("t5_no_writes", 32'(wr), 32'd0);
    chk("t5_pc_hold", {22'd0, pc}, 32'd1023);
`ifdef SUBLEQ_SEQ_PERF_EN
    chk("t5_instret", instret, 32'd1);
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_pc = 10'd11; m_halted = 1'b0; m_instret = 32'd0;
    chk("t5_restart_pc", {22'd0, pc}, 32'd11);
    chk("t5_restart_addr", {22'd0, mif.mem_addr1}, 32'd11);
    chk("t5_restart_busy", {31'd0, busy}, 32'd1);
`ifdef SUBLEQ_SEQ_PERF_EN
    chk("t5_instret_clr", instret, 32'd0);
`endif
    wait_retire(n);
    chk("t5_rerun_data", mif.mem_wdata1, 32'hFFFF_FFFB);
    @(posedge clk); #1;
    chk("t5_rehalt", {31'd0, halted}, 32'd1);

    // stop_req raised in OPERAND lets the write finish, then parks.
    do_reset(); put(11, instr(20, 21, 30)); put(20, 3); put(21, 5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    stop_req = 1'b1;
    @(posedge clk); #1;
    chk("t6a_retire", {31'd0, retire}, 32'd1);
    chk("t6a_wdata", mif.mem_wdata1, 32'd2);
    @(posedge clk); #1;
    stop_req = 1'b0;
    chk("t6a_busy", {31'd0, busy}, 32'd0);
    chk("t6a_pc", {22'd0, pc}, 32'd12);
    chk("t6a_mem", ram[21], 32'd2);
    @(posedge clk); #1;
    chk("t6a_stays_idle", {31'd0, busy}, 32'd0);

    // Reset during EXEC drops the write at once.
    do_reset(); put(21, 5);
    start = 1'b1; stop_req = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_retire(n);
    #2 rst = 1'b1;
    #1;
    chk("t6b_we1", {31'd0, mif.mem_we1}, 32'd0);
    chk("t6b_retire", {31'd0, retire}, 32'd0);
    chk("t6b_pc", {22'd0, pc}, 32'd11);
    chk("t6b_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("t6b_mem", ram[21], 32'd5);
    model_reset();
    stop_req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
